// File: rtl/primus_instruction_decode.sv
// RV32I decode: regfile read with write-first bypass, immediate gen, registered ID/EX bundle; 1-cycle latency.
// Backpressure: if_ready_o = !id_valid_o || ex_ready_i; a stalled bundle holds except for writeback operand refresh.
module primus_instruction_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     ir_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            id_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] npc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            illegal_o
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  logic [XLEN-1:0] rf [32];

  logic            accept;
  logic            stalled;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_rd_data;
  logic [XLEN-1:0] rs2_rd_data;
  logic [XLEN-1:0] imm;
  logic            illegal;
  logic            wb_live;

  assign if_ready_o = !id_valid_o || ex_ready_i;
  assign accept     = if_valid_i && if_ready_o && !flush_i;
  assign stalled    = id_valid_o && !ex_ready_i;
  assign wb_live    = wb_we_i && (wb_rd_i != 5'd0);

  assign opcode = ir_i[6:0];
  assign rs1    = ir_i[19:15];
  assign rs2    = ir_i[24:20];

  // x0 is never written, so rf[0] stays at its reset value of zero.
  assign rs1_rd_data = (wb_live && wb_rd_i == rs1) ? wb_data_i : rf[rs1];
  assign rs2_rd_data = (wb_live && wb_rd_i == rs2) ? wb_data_i : rf[rs2];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{(XLEN-12){ir_i[31]}}, ir_i[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ir_i[31:12], 12'b0};
      OP_JAL:
        imm = {{(XLEN-21){ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      OP_REG, OP_FENCE:
        imm = '0;
      default:
        illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_live) begin
      rf[wb_rd_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_valid_o <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (accept) begin
      id_valid_o <= 1'b1;
    end else if (ex_ready_i) begin
      id_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o       <= '0;
      npc_o      <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      opcode_o   <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else if (accept) begin
      pc_o       <= pc_i;
      npc_o      <= npc_i;
      rs1_data_o <= rs1_rd_data;
      rs2_data_o <= rs2_rd_data;
      imm_o      <= imm;
      rs1_o      <= rs1;
      rs2_o      <= rs2;
      rd_o       <= ir_i[11:7];
      opcode_o   <= opcode;
      funct3_o   <= ir_i[14:12];
      funct7b5_o <= ir_i[30];
      illegal_o  <= illegal;
    end else if (stalled) begin
      // Held operands track writebacks so execute never sees a stale value.
      if (wb_live && wb_rd_i == rs1_o) rs1_data_o <= wb_data_i;
      if (wb_live && wb_rd_i == rs2_o) rs2_data_o <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_primus_instruction_decode.sv
// Directed bench for primus_instruction_decode; inputs change 1ns after the rising edge, outputs are checked there.
module tb_primus_instruction_decode;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] ir_i, pc_i, npc_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        id_valid_o;
  logic        ex_ready_i;
  logic [31:0] pc_o, npc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  primus_instruction_decode #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .ir_i(ir_i), .pc_i(pc_i), .npc_i(npc_i), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i),
    .pc_o(pc_o), .npc_o(npc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .opcode_o(opcode_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
    if_valid_i = 1'b1;
    ir_i       = ir;
    pc_i       = pc;
    npc_i      = pc + 32'd4;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; if_valid_i = 0; ir_i = 0; pc_i = 0; npc_i = 0; flush_i = 0;
    wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0; ex_ready_i = 1;
    step(); step();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", id_valid_o); end
    checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %h exp 1", if_ready_o); end
    checks++; if (imm_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL reset_bundle got imm %h pc %h exp 0", imm_o, pc_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_i_s_type();
    drive(32'h00500093, 32'h100);
    step();
    checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %h exp 1", id_valid_o); end
    checks++; if (imm_o !== 32'd5 || rd_o !== 5'd1 || rs1_data_o !== 32'h0) begin errors++; $display("FAIL addi_fields got imm %h rd %0d rs1d %h", imm_o, rd_o, rs1_data_o); end
    checks++; if (opcode_o !== 7'h13 || pc_o !== 32'h100 || npc_o !== 32'h104) begin errors++; $display("FAIL addi_pc got op %h pc %h npc %h", opcode_o, pc_o, npc_o); end
    drive(32'hFE21AE23, 32'h104);
    step();
    checks++; if (imm_o !== 32'hFFFFFFFC || rs1_o !== 5'd3 || rs2_o !== 5'd2) begin errors++; $display("FAIL sw_fields got imm %h rs1 %0d rs2 %0d", imm_o, rs1_o, rs2_o); end
    checks++; if (funct3_o !== 3'd2 || funct7b5_o !== 1'b1 || illegal_o !== 1'b0) begin errors++; $display("FAIL sw_funct got f3 %0d f7b5 %0d ill %0d", funct3_o, funct7b5_o, illegal_o); end
  endtask

  task automatic test_u_b_j_illegal();
    logic [31:0] irs  [6];
    logic [31:0] imms [6];
    logic        ills [6];
    irs[0] = 32'h123452B7; imms[0] = 32'h12345000; ills[0] = 1'b0;
    irs[1] = 32'h00000000; imms[1] = 32'h00000000; ills[1] = 1'b1;
    irs[2] = 32'hFE000FE3; imms[2] = 32'hFFFFFFFE; ills[2] = 1'b0;
    irs[3] = 32'h000000E3; imms[3] = 32'h00000800; ills[3] = 1'b0;
    irs[4] = 32'h0080006F; imms[4] = 32'h00000008; ills[4] = 1'b0;
    irs[5] = 32'h0010106F; imms[5] = 32'h00001800; ills[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(irs[i], 32'h200 + 32'(i) * 4);
      step();
      checks++; if (imm_o !== imms[i] || illegal_o !== ills[i]) begin errors++; $display("FAIL imm_vec%0d got imm %h ill %0d exp imm %h ill %0d", i, imm_o, illegal_o, imms[i], ills[i]); end
    end
    checks++; if (rd_o !== 5'd0 || id_valid_o !== 1'b1) begin errors++; $display("FAIL jal_rd got rd %0d vld %0d exp 0/1", rd_o, id_valid_o); end
  endtask

  task automatic test_bypass_x0();
    drive(32'h001081B3, 32'h300);
    wb_we_i = 1; wb_rd_i = 5'd1; wb_data_i = 32'hDEADBEEF;
    step();
    checks++; if (rs1_data_o !== 32'hDEADBEEF || rs2_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass got %h %h exp deadbeef", rs1_data_o, rs2_data_o); end
    checks++; if (rd_o !== 5'd3 || imm_o !== 32'h0) begin errors++; $display("FAIL add_fields got rd %0d imm %h", rd_o, imm_o); end
    drive(32'h00000093, 32'h304);
    wb_we_i = 1; wb_rd_i = 5'd0; wb_data_i = 32'h1234;
    step();
    checks++; if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rs1_data_o); end
    wb_we_i = 0;
    drive(32'h00008113, 32'h308);
    step();
    checks++; if (rs1_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL x1_stored got %h exp deadbeef", rs1_data_o); end
    drive(32'h00000093, 32'h30C);
    step();
    checks++; if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp 0", rs1_data_o); end
  endtask

  task automatic test_stall_refresh();
    drive(32'h00008113, 32'h400);
    step();
    ex_ready_i = 0;
    drive(32'h00500093, 32'h404);
    #1;
    checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %h exp 0", if_ready_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (id_valid_o !== 1'b1 || pc_o !== 32'h400 || rs1_data_o !== 32'hDEADBEEF || rd_o !== 5'd2) begin errors++; $display("FAIL stall_hold%0d got vld %0d pc %h rs1d %h rd %0d", i, id_valid_o, pc_o, rs1_data_o, rd_o); end
    end
    wb_we_i = 1; wb_rd_i = 5'd1; wb_data_i = 32'h55;
    step();
    wb_we_i = 0;
    checks++; if (rs1_data_o !== 32'h55 || rs2_data_o !== 32'h0 || pc_o !== 32'h400) begin errors++; $display("FAIL refresh got rs1d %h rs2d %h pc %h", rs1_data_o, rs2_data_o, pc_o); end
    ex_ready_i = 1;
    #1;
    checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %h exp 1", if_ready_o); end
    step();
    checks++; if (id_valid_o !== 1'b1 || pc_o !== 32'h404 || imm_o !== 32'd5) begin errors++; $display("FAIL release_accept got vld %0d pc %h imm %h", id_valid_o, pc_o, imm_o); end
    if_valid_i = 0;
    step();
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL drain got %h exp 0", id_valid_o); end
  endtask

  task automatic test_flush();
    drive(32'h00500093, 32'h500);
    step();
    flush_i = 1;
    drive(32'h123452B7, 32'h504);
    step();
    flush_i = 0;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_accept got %h exp 0", id_valid_o); end
    drive(32'h123452B7, 32'h508);
    step();
    checks++; if (id_valid_o !== 1'b1 || pc_o !== 32'h508 || rd_o !== 5'd5) begin errors++; $display("FAIL post_flush got vld %0d pc %h rd %0d", id_valid_o, pc_o, rd_o); end
    ex_ready_i = 0; if_valid_i = 0;
    step();
    flush_i = 1;
    step();
    flush_i = 0;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %h exp 0", id_valid_o); end
    ex_ready_i = 1;
  endtask

  task automatic test_reset_mid();
    wb_we_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'h77;
    drive(32'h00008113, 32'h600);
    step();
    wb_we_i = 0;
    if_valid_i = 0;
    rst_i = 1;
    #1;
    checks++; if (id_valid_o !== 1'b0 || pc_o !== 32'h0 || rs1_data_o !== 32'h0 || rd_o !== 5'd0) begin errors++; $display("FAIL reset_mid got vld %0d pc %h rs1d %h rd %0d", id_valid_o, pc_o, rs1_data_o, rd_o); end
    step();
    rst_i = 0;
    drive(32'h00028313, 32'h700);
    step();
    checks++; if (id_valid_o !== 1'b1 || rs1_data_o !== 32'h0 || rs1_o !== 5'd5) begin errors++; $display("FAIL x5_after_reset got vld %0d rs1d %h rs1 %0d", id_valid_o, rs1_data_o, rs1_o); end
  endtask

  initial begin
    test_reset();
    test_i_s_type();
    test_u_b_j_illegal();
    test_bypass_x0();
    test_stall_refresh();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
